// File: rtl/ram_cmd_if.sv
// Bundle of signals between ram_cmd_master, its requester and the RAM slave:
// request port, command stream to RAM din/rx_valid, RAM read-back and response.
interface ram_cmd_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic [ADDR_WIDTH+1:0] cmd_din;
   logic                  cmd_valid;
   logic [DATA_WIDTH-1:0] ram_dout;
   logic                  ram_tx_valid;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, ram_dout, ram_tx_valid,
      output req_ready, cmd_din, cmd_valid, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, ram_dout, ram_tx_valid,
      input  req_ready, cmd_din, cmd_valid, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/ram_cmd_master.sv
// Serialises single read/write requests into the two-word RAM command sequence
// (address word, then data or read-trigger word) and returns read data or a timeout.
module ram_cmd_master #(
   parameter int ADDR_WIDTH     = 8,
   parameter int DATA_WIDTH     = 8,
   parameter int GAP_CYCLES     = 1,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   ram_cmd_if.master  bus
);

   localparam int CMD_WIDTH = ADDR_WIDTH + 2;
   localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
   localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      GAP,
      DATA,
      WAIT_RD,
      RESP
   } state_t;

   state_t                state;
   logic                  write_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [15:0]           cnt;
   logic [CMD_WIDTH-1:0]  data_word;

   // Second command word: write data for writes, an all-zero read trigger for reads.
   assign data_word = write_q ? {2'b01, wdata_q} : {2'b11, {ADDR_WIDTH{1'b0}}};

   // Outputs are loaded on the edge that enters each state, so they are registered
   // and already valid in the first cycle of that state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         bus.req_ready <= 1'b1;
         bus.cmd_din   <= '0;
         bus.cmd_valid <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
         write_q       <= 1'b0;
         wdata_q       <= '0;
         cnt           <= '0;
      end else begin
         bus.cmd_valid <= 1'b0;
         bus.rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req_valid && bus.req_ready) begin
                  write_q       <= bus.req_write;
                  wdata_q       <= bus.req_wdata;
                  bus.cmd_din   <= {(bus.req_write ? 2'b00 : 2'b10), bus.req_addr};
                  bus.cmd_valid <= 1'b1;
                  bus.req_ready <= 1'b0;
                  state         <= ADDR;
               end
            end
            ADDR: begin
               if (GAP_CYCLES > 0) begin
                  cnt   <= '0;
                  state <= GAP;
               end else begin
                  bus.cmd_din   <= data_word;
                  bus.cmd_valid <= 1'b1;
                  state         <= DATA;
               end
            end
            GAP: begin
               if (cnt == GAP_LAST) begin
                  bus.cmd_din   <= data_word;
                  bus.cmd_valid <= 1'b1;
                  state         <= DATA;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            DATA: begin
               if (write_q) begin
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_rdata <= '0;
                  bus.rsp_err   <= 1'b0;
                  state         <= RESP;
               end else begin
                  cnt   <= '0;
                  state <= WAIT_RD;
               end
            end
            // Returned data takes priority over a timeout falling in the same cycle.
            WAIT_RD: begin
               if (bus.ram_tx_valid) begin
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_rdata <= bus.ram_dout;
                  bus.rsp_err   <= 1'b0;
                  state         <= RESP;
               end else if (cnt == TO_LAST) begin
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_rdata <= '0;
                  bus.rsp_err   <= 1'b1;
                  state         <= RESP;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            RESP: begin
               bus.req_ready <= 1'b1;
               state         <= IDLE;
            end
            default: begin
               bus.req_ready <= 1'b1;
               state         <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/ram_cmd_master.md
Name: ram_cmd_master

Overview:
Initiator side of the 10-bit RAM command interface. Accepts single-word read/write requests on a valid/ready port and serialises each one into the two-word command sequence the RAM slave expects on din/rx_valid. Write sequence: address word (tag 00), then data word (tag 01). Read sequence: address word (tag 10), then read-trigger word (tag 11). For reads, the block collects dout/tx_valid from the RAM and returns the data, or flags a timeout. Sits between the SPI/control logic and the RAM; drives the RAM's din/rx_valid and consumes its dout/tx_valid.

Parameters:
ADDR_WIDTH, 8, RAM address width; command word width is ADDR_WIDTH+2.
DATA_WIDTH, 8, RAM data width; must equal ADDR_WIDTH.
GAP_CYCLES, 1, idle cycles with cmd_valid=0 between the two command words (0 allowed).
TIMEOUT_CYCLES, 16, maximum cycles spent in WAIT_RD waiting for ram_tx_valid (range 1..255).

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request; high only in IDLE.
req_write  in  1  1 = write, 0 = read.
req_addr  in  ADDR_WIDTH  target address.
req_wdata  in  DATA_WIDTH  write data; ignored for reads.
cmd_din  out  ADDR_WIDTH+2  command word to RAM din; [9:8] tag, [7:0] payload.
cmd_valid  out  1  to RAM rx_valid; one-cycle pulse per word.
ram_dout  in  DATA_WIDTH  RAM read data.
ram_tx_valid  in  1  RAM read data valid.
rsp_valid  out  1  one-cycle completion pulse; no backpressure.
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
rsp_err  out  1  1 = read timed out; qualified by rsp_valid.

Behaviour:
- Reset: state=IDLE; req_ready=1 in the first cycle after reset. cmd_din=0, cmd_valid=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. Internal counters and request registers are cleared.
- Reset mid-operation aborts the sequence: no further command words and no rsp pulse. The RAM is left in whatever state it reached.
- All outputs are registered.
- Handshake: a request is accepted on an edge where req_valid & req_ready. req_addr, req_write and req_wdata are captured at that edge. req_ready is low from the next cycle until the block returns to IDLE.
- IDLE: req_ready=1, cmd_valid=0. On accept, go to ADDR.
- ADDR: one cycle. cmd_valid=1; cmd_din = {2'b00, addr} for a write, {2'b10, addr} for a read.
  - GAP_CYCLES>0: go to GAP. GAP_CYCLES=0: go to DATA.
- GAP: cmd_valid=0, cmd_din holds its last value, for exactly GAP_CYCLES cycles; then go to DATA.
- DATA: one cycle. cmd_valid=1.
  - Write: cmd_din = {2'b01, wdata}; go to RESP with rsp_err=0, rsp_rdata=0.
  - Read: cmd_din = {2'b11, 8'h00}; go to WAIT_RD with the wait counter cleared.
- WAIT_RD: cmd_valid=0; the counter increments each cycle.
  - If ram_tx_valid=1: capture ram_dout into rsp_rdata, set rsp_err=0, go to RESP.
  - Else, if the counter reaches TIMEOUT_CYCLES-1: rsp_rdata=0, rsp_err=1, go to RESP.
  - If ram_tx_valid arrives in the timeout cycle itself, the data wins (err=0).
- RESP: rsp_valid=1 for one cycle; go to IDLE. rsp_rdata/rsp_err hold until the next RESP.
- ram_tx_valid is ignored in every state except WAIT_RD; a stray pulse produces no response.
- Latency, accept edge = cycle 0:
  - ADDR word in cycle 1; DATA word in cycle 2+GAP_CYCLES.
  - Write rsp_valid in cycle 3+GAP_CYCLES; next accept possible in cycle 4+GAP_CYCLES.
  - Read rsp_valid is one cycle after the ram_tx_valid cycle.
- cmd_valid is never high in two consecutive cycles when GAP_CYCLES>0.

Test Plan:
- Write: reset, then req write addr=0x05 wdata=0xBB, GAP_CYCLES=1 -> cmd_din=0x005 with cmd_valid in cycle 1; cmd_valid=0 in cycle 2; 0x1BB in cycle 3; rsp_valid=1, rsp_err=0 in cycle 4; req_ready=1 in cycle 5.
- Read: RAM model holds 0xBB at 0x05 and asserts tx_valid one cycle after the 11-tag word; req read addr=0x05 -> cmd_din 0x205 then 0x300; rsp_valid with rsp_rdata=0xBB, rsp_err=0.
- Write then read 0x06<-0xCC; then overwrite 0x05<-0xCC and read 0x05 -> reads return 0xCC and 0xCC; req_valid held high throughout, and req_ready is low during each sequence.
- Timeout: read with no ram_tx_valid, TIMEOUT_CYCLES=16 -> rsp_valid with rsp_err=1, rsp_rdata=0 exactly 16 cycles after entering WAIT_RD; block is back in IDLE.
- Stray/edge: ram_tx_valid pulsed in IDLE -> no rsp_valid. tx_valid in the last timeout cycle with dout=0x3C -> rsp_rdata=0x3C, rsp_err=0.
- Reset mid-read: assert rst during GAP -> next cycle cmd_valid=0, cmd_din=0, req_ready=1 after release, no rsp_valid; a following write to 0x07 completes normally.
